// File: rtl/rv_mc_ctrl.sv
// Multi-cycle sequencing controller for the rv32 core: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB and issues per-cycle datapath enables with ready handshakes.
module rv_mc_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             halt_req,
    output logic             imem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_src,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_we,
    output logic             mem_to_reg,
    output logic [2:0]       state,
    output logic             retire,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             illegal_op
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6,
        StTrap   = 3'd7
    } state_e;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpIAlu   = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OpR, OpIAlu, OpLoad, OpStore, OpBranch,
            OpJal, OpJalr, OpLui, OpAuipc: is_legal = 1'b1;
            default:                       is_legal = 1'b0;
        endcase
    endfunction

    state_e           state_q, state_d;
    logic [6:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_e           boundary_st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= 7'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        reg_we     = 1'b0;
        mem_to_reg = 1'b0;
        illegal_op = 1'b0;
        // Every instruction boundary diverts to HALT while a halt is requested.
        boundary_st = halt_req ? StHalt : StFetch;

        unique case (state_q)
            StIdle: state_d = boundary_st;
            StFetch: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                op_d    = opcode;
                state_d = is_legal(opcode) ? StExec : StTrap;
            end
            StExec: begin
                case (op_q)
                    OpBranch: begin
                        pc_we   = 1'b1;
                        pc_src  = branch_taken;
                        state_d = boundary_st;
                    end
                    OpLoad, OpStore: state_d = StMem;
                    default:         state_d = StWb;
                endcase
            end
            StMem: begin
                dmem_req = 1'b1;
                dmem_we  = (op_q == OpStore);
                if (dmem_ready) begin
                    if (op_q == OpStore) begin
                        pc_we   = 1'b1;
                        state_d = boundary_st;
                    end else begin
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                reg_we     = 1'b1;
                mem_to_reg = (op_q == OpLoad);
                pc_we      = 1'b1;
                pc_src     = (op_q == OpJal) || (op_q == OpJalr);
                state_d    = boundary_st;
            end
            StHalt: begin
                if (!halt_req) state_d = StFetch;
            end
            StTrap: illegal_op = 1'b1;
        endcase

        // The single PC update of an instruction is its retirement point.
        retire = pc_we;
        cnt_d  = retire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    assign state       = state_q;
    assign retired_cnt = cnt_q;

endmodule
